// File: rtl/line_fifo_sync.sv
// Synchronous single-clock line FIFO with registered status flags, water level and error pulses.
// Define LINE_FIFO_FWFT_EN for first-word-fall-through reads; default build is a registered-read FIFO.
module line_fifo_sync #(
  parameter int DATA_WIDTH       = 24,
  parameter int ADDR_WIDTH       = 8,
  parameter int ALMOST_FULL_NUM  = 252,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk_tb,
  input  logic                  tb_rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   water_level,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level_next;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags are registered, so a request against full/empty is judged on the pre-edge state.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    level_next = water_level;
    if (wr_acc && !rd_acc)
      level_next = water_level + ONE_L;
    else if (rd_acc && !wr_acc)
      level_next = water_level - ONE_L;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      water_level  <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      wr_err       <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc)
        rd_ptr <= rd_ptr + PTR_ONE;
      water_level  <= level_next;
      full         <= (level_next == DEPTH_L);
      empty        <= (level_next == '0);
      almost_full  <= (level_next >= AF_L);
      almost_empty <= (level_next <= AE_L);
      wr_err       <= wr_en & full;
      rd_err       <= rd_en & empty;
    end
  end

  // NOTE: the storage array has no reset; reset pointers and level make stale contents unreachable.
  always_ff @(posedge clk_tb) begin
    if (wr_acc)
      mem[wr_ptr] <= wr_data;
  end

`ifdef LINE_FIFO_FWFT_EN
  logic [ADDR_WIDTH-1:0] rd_ptr_nx;
  assign rd_ptr_nx = rd_ptr + PTR_ONE;

  // rd_data mirrors the head word; a write into an empty FIFO bypasses the array.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      rd_data <= '0;
    end else if (rd_acc) begin
      if (water_level > ONE_L)
        rd_data <= mem[rd_ptr_nx];
      else if (wr_acc)
        rd_data <= wr_data;
    end else if (wr_acc && empty) begin
      rd_data <= wr_data;
    end
  end
`else
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst)
      rd_data <= '0;
    else if (rd_acc)
      rd_data <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_line_fifo_sync.sv
// Scoreboard bench for line_fifo_sync: a queue model tracks contents, a negedge monitor compares outputs.
// Honours LINE_FIFO_FWFT_EN the same way the design does.
module tb_line_fifo_sync;

  localparam int DW    = 24;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int AFN   = 252;
  localparam int AEN   = 4;

  logic          clk_tb = 1'b0;
  logic          tb_rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   water_level;
  logic          wr_err, rd_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] sb_q[$];
  bit            rd_fire    = 1'b0;
  bit            exp_wr_err = 1'b0;
  bit            exp_rd_err = 1'b0;
  logic [DW-1:0] last_rd    = '0;
  logic [DW-1:0] head_exp   = '0;

  line_fifo_sync #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)
  ) dut (
    .clk_tb(clk_tb), .tb_rst(tb_rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .water_level(water_level), .wr_err(wr_err), .rd_err(rd_err)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, acceptance judged on pre-edge occupancy.
  always @(posedge clk_tb) begin
    int lvl;
    bit wa, ra;
    if (!tb_rst) begin
      lvl = model_q.size();
      wa = wr_en && (lvl < DEPTH);
      ra = rd_en && (lvl > 0);
      exp_wr_err = wr_en && (lvl == DEPTH);
      exp_rd_err = rd_en && (lvl == 0);
      rd_fire = ra;
      if (ra) sb_q.push_back(model_q.pop_front());
      if (wa) model_q.push_back(wr_data);
      if (model_q.size() > 0) head_exp = model_q[0];
    end
  end

  // Monitor: compare every registered output half a cycle after each edge.
  always @(negedge clk_tb) begin
    int lvl;
    if (!tb_rst) begin
      lvl = model_q.size();
      check("water_level", 32'(water_level), 32'(lvl));
      check("full", 32'(full), 32'(lvl == DEPTH));
      check("empty", 32'(empty), 32'(lvl == 0));
      check("almost_full", 32'(almost_full), 32'(lvl >= AFN));
      check("almost_empty", 32'(almost_empty), 32'(lvl <= AEN));
      check("wr_err", 32'(wr_err), 32'(exp_wr_err));
      check("rd_err", 32'(rd_err), 32'(exp_rd_err));
`ifdef LINE_FIFO_FWFT_EN
      check("rd_data_head", 32'(rd_data), 32'(head_exp));
`else
      if (rd_fire) begin
        rd_fire = 1'b0;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual=read expected=none t=%0t", $time);
        end else begin
          last_rd = sb_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(last_rd));
        end
      end else begin
        check("rd_data_hold", 32'(rd_data), 32'(last_rd));
      end
`endif
    end
  end

  task automatic step(bit w, logic [DW-1:0] d, bit r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk_tb);
    #1;
  endtask

  task automatic reset_checks(string tag);
    check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
    check({tag, "_level"}, 32'(water_level), 32'h0);
    check({tag, "_empty"}, 32'(empty), 32'h1);
    check({tag, "_aempty"}, 32'(almost_empty), 32'h1);
    check({tag, "_full"}, 32'(full), 32'h0);
    check({tag, "_afull"}, 32'(almost_full), 32'h0);
    check({tag, "_wr_err"}, 32'(wr_err), 32'h0);
    check({tag, "_rd_err"}, 32'(rd_err), 32'h0);
  endtask

  // Asserted between edges so the checks below observe the asynchronous clear.
  task automatic do_reset(string tag);
    #2;
    tb_rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_q.delete();
    sb_q.delete();
    rd_fire = 1'b0;
    exp_wr_err = 1'b0;
    exp_rd_err = 1'b0;
    last_rd = '0;
    head_exp = '0;
    #1;
    reset_checks(tag);
    @(negedge clk_tb);
    #2;
    tb_rst = 1'b0;
  endtask

  initial begin
    int wp, rp;
    tb_rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = '0;
    #2;
    reset_checks("por");
    @(negedge clk_tb);
    #2;
    tb_rst = 1'b0;

    // Fill 1..256: almost_full after write 252, full after write 256.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0);
      if (i == AFN - 1) check("fill_af_before", 32'(almost_full), 32'h0);
      if (i == AFN)     check("fill_af_at", 32'(almost_full), 32'h1);
      if (i == DEPTH-1) check("fill_full_before", 32'(full), 32'h0);
    end
    check("fill_full", 32'(full), 32'h1);
    check("fill_level", 32'(water_level), 32'd256);

    // Overflow: dropped write pulses wr_err for one cycle.
    step(1'b1, 24'hABCDEF, 1'b0);
    check("ovf_wr_err", 32'(wr_err), 32'h1);
    step(1'b0, '0, 1'b0);
    check("ovf_wr_err_clear", 32'(wr_err), 32'h0);

    // Drain: scoreboard expects 1..256 in order, never 0xABCDEF.
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    check("drain_empty", 32'(empty), 32'h1);

    // Underflow: rd_err pulses and rd_data keeps the last word.
    step(1'b0, '0, 1'b1);
    check("udf_rd_err", 32'(rd_err), 32'h1);
    check("udf_rd_hold", 32'(rd_data), 32'd256);
    step(1'b0, '0, 1'b0);
    check("udf_rd_err_clear", 32'(rd_err), 32'h0);

`ifdef LINE_FIFO_FWFT_EN
    // Fall-through: the first word is visible right after its write edge.
    step(1'b1, 24'h000007, 1'b0);
    check("fwft_rd_data", 32'(rd_data), 32'h7);
    check("fwft_empty", 32'(empty), 32'h0);
    step(1'b0, '0, 1'b1);
`endif

    // Wrap: 300 writes while reading most cycles pushes both pointers past DEPTH-1.
    for (int i = 0; i < 300; i++) step(1'b1, DW'($urandom), ($urandom_range(99) < 75));
    while (model_q.size() > 0) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Simultaneous read and write at level 10 holds level and flags.
    for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, DW'($urandom), 1'b1);
    check("simul_level", 32'(water_level), 32'd10);
    check("simul_aempty", 32'(almost_empty), 32'h0);

    // Reset at level 100 discards everything; the first post-reset word reads back first.
    while (model_q.size() < 100) step(1'b1, DW'($urandom), 1'b0);
    check("pre_rst_level", 32'(water_level), 32'd100);
    do_reset("mid");
    step(1'b1, 24'h000055, 1'b0);
`ifdef LINE_FIFO_FWFT_EN
    check("post_rst_fwft", 32'(rd_data), 32'h55);
`endif
    step(1'b0, '0, 1'b1);
    check("post_rst_read", 32'(rd_data), 32'h55);
    step(1'b0, '0, 1'b0);

    // Random traffic with shifting bias to revisit full, empty and the thresholds.
    for (int ph = 0; ph < 8; ph++) begin
      wp = (ph % 2 == 0) ? 85 : 20;
      rp = (ph % 2 == 0) ? 25 : 85;
      if (ph == 6) begin wp = 50; rp = 50; end
      for (int i = 0; i < 250; i++)
        step(($urandom_range(99) < wp), DW'($urandom), ($urandom_range(99) < rp));
    end
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_fifo_sync.md
LINE_FIFO_SYNC -- requirements
Module: line_fifo_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, word width in bits (1..256).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, giving depth DEPTH = 2**ADDR_WIDTH (4..10).
REQ-003 SHALL have parameter ALMOST_FULL_NUM, default 252, almost_full threshold (1..DEPTH-1).
REQ-004 SHALL have parameter ALMOST_EMPTY_NUM, default 4, almost_empty threshold (1..DEPTH-1).
REQ-005 SHALL have port clk_tb, input, 1, single clock for all logic.
REQ-006 SHALL have port tb_rst, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have port wr_en, input, 1, write request.
REQ-008 SHALL have port wr_data, input, DATA_WIDTH, write word.
REQ-009 SHALL have port rd_en, input, 1, read request.
REQ-010 SHALL have port rd_data, output, DATA_WIDTH, read word.
REQ-011 SHALL have ports full, empty, almost_full and almost_empty, each output, 1, status flags.
REQ-012 SHALL have port water_level, output, ADDR_WIDTH+1, stored word count (0..DEPTH).
REQ-013 SHALL have ports wr_err and rd_err, each output, 1, one-cycle overflow/underflow pulses.

Function
REQ-014 SHALL accept a write on a rising edge when wr_en=1 and full=0; when full=1, the write SHALL be dropped even if a read is accepted on the same edge.
REQ-015 SHALL accept a read on a rising edge when rd_en=1 and empty=0; when empty=1, the read SHALL be dropped even if a write is accepted on the same edge.
REQ-016 SHALL update water_level every edge: +1 on write only, -1 on read only, unchanged on both or neither; it SHALL never wrap.
REQ-017 SHALL wrap write and read pointers from DEPTH-1 to 0 without data loss.
REQ-018 SHALL drive full=1 when water_level=DEPTH, and empty=1 when water_level=0; all flags SHALL be registered and valid on the edge of the count change.
REQ-019 SHALL drive almost_full=1 when water_level>=ALMOST_FULL_NUM, and almost_empty=1 when water_level<=ALMOST_EMPTY_NUM.
REQ-020 SHALL pulse wr_err high for one cycle, on the edge after wr_en=1 with full=1; rd_err SHALL behave the same for rd_en=1 with empty=1.
REQ-021 Standard mode: rd_data SHALL be registered, presenting the accepted word one cycle after the read edge and holding its value otherwise.
REQ-022 SHALL preserve FIFO order exactly; the first word written SHALL be the first word read.

Reset
REQ-023 tb_rst=1 SHALL immediately clear the pointers, water_level, rd_data, full, almost_full, wr_err and rd_err to 0, and set empty and almost_empty to 1.
REQ-024 Reset mid-operation SHALL discard all stored words; requests SHALL be ignored while tb_rst=1, and the first write after release SHALL be read back first.

Configuration
REQ-025 With macro LINE_FIFO_FWFT_EN defined, the block SHALL operate first-word-fall-through:
- rd_data SHALL show the head word whenever empty=0;
- the first write into an empty FIFO SHALL appear on rd_data, and empty SHALL drop, on the same edge as the write;
- an accepted read SHALL advance rd_data to the next word on that edge.
REQ-026 Without LINE_FIFO_FWFT_EN, standard mode (REQ-021) SHALL apply, and no FWFT logic SHALL be synthesised.

Verification (DATA_WIDTH=24, ADDR_WIDTH=8)
REQ-027 Fill test: write 1..256 on consecutive edges -> almost_full rises after write 252, full rises after write 256, water_level=256.
REQ-028 Overflow test: with the FIFO full, write 0xABCDEF -> wr_err pulses one cycle; a 256-read drain returns 1..256 in order, and 0xABCDEF never appears.
REQ-029 Underflow/wrap test: drain to empty, then rd_en=1 -> rd_err pulses and rd_data holds; then write 300 words while reading -> pointers wrap and the data stays ordered.
REQ-030 Simultaneous test: at water_level=10, assert wr_en and rd_en together for 20 cycles -> water_level stays 10 and the flags do not change.
REQ-031 Reset test: assert tb_rst at water_level=100 -> empty=1, water_level=0 and rd_data=0 immediately; after release, write 0x000055 and read it back -> 0x000055.
REQ-032 FWFT test: with LINE_FIFO_FWFT_EN defined, write 0x000007 into an empty FIFO -> rd_data=0x000007 with empty=0 after that edge, with no read needed.
